// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous sig_in over a gate window of GATE_CYCLES clk cycles.
// Define FREQ_METER_CONT_EN for back-to-back continuous measurement; otherwise each start gives one shot.
module freq_meter #(
   parameter int unsigned GATE_CYCLES = 1000,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned EXP_MIN     = 240,
   parameter int unsigned EXP_MAX     = 260
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sig_in,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] count,
   output logic             in_range,
   output logic             overflow
);

   localparam int unsigned      TMR_W    = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {S_IDLE, S_GATE, S_DONE} state_e;

   state_e           state_q, state_d;
   logic [2:0]       sync_q;
   logic             sig_rise;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             capture;
   logic [63:0]      cnt_ext;
   logic [CNT_W-1:0] count_q;
   logic             in_range_q, overflow_q;

   // sync_q[1:0] is the two-flop synchronizer; sync_q[2] delays stage 2 for rise detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[1:0], sig_in};
   end

   assign sig_rise = sync_q[1] & ~sync_q[2];

   always_comb begin
      // NOTE: every variable gets a default first so no branch can leave it unassigned and infer a latch.
      state_d = state_q;
      timer_d = timer_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      capture = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_GATE;
               timer_d = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         S_GATE: begin
            timer_d = timer_q + 1'b1;
            if (sig_rise && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
            ovf_d = ovf_q | (cnt_d == CNT_MAX);
            if (timer_q == TMR_LAST) begin
               state_d = S_DONE;
               capture = 1'b1;
            end
         end
         S_DONE: begin
`ifdef FREQ_METER_CONT_EN
            state_d = S_GATE;
            timer_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
`else
            state_d = S_IDLE;
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign cnt_ext = 64'(cnt_d);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   // Results are taken on the last gate cycle so they are valid together with done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q    <= '0;
         in_range_q <= 1'b0;
         overflow_q <= 1'b0;
      end else if (capture) begin
         count_q    <= cnt_d;
         overflow_q <= ovf_d;
         in_range_q <= !ovf_d && (cnt_ext >= 64'(EXP_MIN)) && (cnt_ext <= 64'(EXP_MAX));
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);
   assign count    = count_q;
   assign in_range = in_range_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: random sig_in waveforms against an edge-counting reference built from sampled history.
// A second instance with CNT_W=4 exercises saturation; FREQ_METER_CONT_EN selects the continuous scenario.
module tb_freq_meter;

   localparam int G    = 1000;
   localparam int EMIN = 240;
   localparam int EMAX = 260;
   localparam int HMAX = 50000;

   logic        clk = 1'b0;
   logic        rst, start, sig_in;
   logic        busy_a, done_a, in_range_a, overflow_a;
   logic [15:0] count_a;
   logic        busy_b, done_b, in_range_b, overflow_b;
   logic [3:0]  count_b;

   int n_vec = 0;
   int n_bad = 0;

   freq_meter #(.GATE_CYCLES(G), .CNT_W(16), .EXP_MIN(EMIN), .EXP_MAX(EMAX)) u_dut_a (
      .clk(clk), .rst(rst), .start(start), .sig_in(sig_in),
      .busy(busy_a), .done(done_a), .count(count_a), .in_range(in_range_a), .overflow(overflow_a)
   );

   freq_meter #(.GATE_CYCLES(G), .CNT_W(4), .EXP_MIN(EMIN), .EXP_MAX(EMAX)) u_dut_b (
      .clk(clk), .rst(rst), .start(start), .sig_in(sig_in),
      .busy(busy_b), .done(done_b), .count(count_b), .in_range(in_range_b), .overflow(overflow_b)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Value the first synchronizer flop takes at each rising clk edge (held low by reset).
   bit hist [0:HMAX-1];
   int cyc = 0;
   always @(posedge clk) begin
      if (cyc < HMAX) hist[cyc] = rst ? 1'b0 : sig_in;
      cyc++;
   end

   // Stimulus modes: 0 low, 1 high, 2 80 ns period, 3 random half-periods hmin..hmax cycles.
   int mode = 0;
   int hmin = 1;
   int hmax = 1;
   int left = 1;
   initial begin
      sig_in = 1'b0;
      forever begin
         @(negedge clk);
         if (mode == 0) sig_in = 1'b0;
         else if (mode == 1) sig_in = 1'b1;
         else if (left <= 1) begin
            sig_in = ~sig_in;
            left   = (mode == 2) ? 2 : int'($urandom_range(hmin, hmax));
         end else left--;
      end
   end

   // A sampled rise at edge k is detected two edges later; the window with start taken
   // at edge e0 counts detections on edges e0+1 .. e0+G.
   function automatic int rises(input int e0);
      int r = 0;
      for (int k = e0 - 1; k <= e0 + G - 2; k++)
         if (hist[k] && !hist[k-1]) r++;
      return r;
   endfunction

   task automatic check_result(input string tag, input int r, input logic [15:0] ca, input logic ia,
                               input logic oa, input logic [3:0] cb, input logic ib, input logic ob);
      int  sat_a, sat_b;
      bit  ovf_a, ovf_b;
      sat_a = (r > 65535) ? 65535 : r;
      ovf_a = (r >= 65535);
      sat_b = (r > 15) ? 15 : r;
      ovf_b = (r >= 15);
      check({tag, "/count"}, 32'(ca), 32'(sat_a));
      check({tag, "/ovf"}, 32'(oa), 32'(ovf_a));
      check({tag, "/in_range"}, 32'(ia), 32'(!ovf_a && sat_a >= EMIN && sat_a <= EMAX));
      check({tag, "/count_w4"}, 32'(cb), 32'(sat_b));
      check({tag, "/ovf_w4"}, 32'(ob), 32'(ovf_b));
      check({tag, "/in_range_w4"}, 32'(ib), 32'(!ovf_b && sat_b >= EMIN && sat_b <= EMAX));
      if (mode == 2) check({tag, "/band_249_251"}, 32'(ca >= 249 && ca <= 251), 1);
   endtask

   task automatic measure(input string tag, input bit restart_mid, input bit from_reset);
      int          e0, dones, r;
      logic [15:0] ca = '1;
      logic [3:0]  cb = '1;
      logic        ia = 1'bx, oa = 1'bx, ib = 1'bx, ob = 1'bx;
      dones = 0;
      @(negedge clk);
      if (from_reset) rst = 1'b0;
      start = 1'b1;
      e0 = cyc;
      @(negedge clk);
      start = 1'b0;
      check({tag, "/busy"}, 32'(busy_a), 1);
      while (cyc <= e0 + G + 5) begin
         start = restart_mid && (cyc == e0 + 10);
         if (done_a) begin
            dones++;
            check({tag, "/done_at"}, 32'(cyc - 1 - e0), 32'(G));
            check({tag, "/done_w4"}, 32'(done_b), 1);
            ca = count_a; ia = in_range_a; oa = overflow_a;
            cb = count_b; ib = in_range_b; ob = overflow_b;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check({tag, "/done_pulses"}, 32'(dones), 1);
      r = rises(e0);
      check_result(tag, r, ca, ia, oa, cb, ib, ob);
      check({tag, "/hold_count"}, 32'(count_a), 32'((r > 65535) ? 65535 : r));
      check({tag, "/idle_busy"}, 32'(busy_a), 0);
   endtask

   task automatic run_cont();
      int e0, e_first, ndones, r;
      bit busy_drop;
      ndones    = 0;
      busy_drop = 1'b0;
      mode      = 2;
      @(negedge clk);
      start   = 1'b1;
      e0      = cyc;
      e_first = cyc;
      @(negedge clk);
      start = 1'b0;
      while (ndones < 3 && cyc < e_first + 3 * (G + 1) + 20) begin
         if (!busy_a) busy_drop = 1'b1;
         if (done_a) begin
            check("cont/done_at", 32'(cyc - 1 - e0), 32'(G));
            r = rises(e0);
            check_result("cont", r, count_a, in_range_a, overflow_a, count_b, in_range_b, overflow_b);
            e0 += G + 1;
            ndones++;
         end
         @(negedge clk);
      end
      check("cont/done_pulses", 32'(ndones), 3);
      check("cont/busy_drop", 32'(busy_drop), 0);
   endtask

   initial begin
      bit seen;
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("rst/busy", 32'(busy_a), 0);
      check("rst/done", 32'(done_a), 0);
      check("rst/count", 32'(count_a), 0);
      check("rst/in_range", 32'(in_range_a), 0);
      check("rst/overflow", 32'(overflow_a), 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
`ifdef FREQ_METER_CONT_EN
      run_cont();
`else
      mode = 0;
      repeat (4) @(negedge clk);
      measure("held_low", 1'b0, 1'b0);
      check("held_low/zero", 32'(count_a), 0);
      mode = 1;
      repeat (4) @(negedge clk);
      measure("held_high", 1'b0, 1'b0);
      check("held_high/zero", 32'(count_a), 0);
      mode = 2;
      measure("p80_a", 1'b0, 1'b0);
      measure("p80_b", 1'b0, 1'b0);
      measure("restart_ignored", 1'b1, 1'b0);
      hmin = 1; hmax = 1; mode = 3;
      measure("fastest", 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         hmin = $urandom_range(1, 3);
         hmax = hmin + $urandom_range(0, 3);
         measure("random", 1'b0, 1'b0);
      end

      // Abort a window half way with an asynchronous reset, then restart on the release edge.
      mode = 2;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 1'b0;
      repeat (500) begin
         @(negedge clk);
         if (done_a) seen = 1'b1;
      end
      #3 rst = 1'b1;
      #1;
      check("abort/busy", 32'(busy_a), 0);
      check("abort/done", 32'(done_a), 0);
      check("abort/count", 32'(count_a), 0);
      check("abort/in_range", 32'(in_range_a), 0);
      check("abort/overflow", 32'(overflow_a), 0);
      check("abort/count_w4", 32'(count_b), 0);
      repeat (3) begin
         @(negedge clk);
         if (done_a) seen = 1'b1;
      end
      check("abort/no_done", 32'(seen), 0);
      measure("post_reset", 1'b0, 1'b1);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 1000; gate window length in clk cycles, minimum 2.
REQ-002 Parameter CNT_W, default 16; width of the edge counter and the count output.
REQ-003 Parameter EXP_MIN, default 240; lowest count accepted as in range.
REQ-004 Parameter EXP_MAX, default 260; highest count accepted as in range.
REQ-005 Port clk, input, 1 bit; system clock (50 MHz), all state on its rising edge.
REQ-006 Port rst, input, 1 bit; asynchronous, active-high reset.
REQ-007 Port start, input, 1 bit; single-cycle request to begin one measurement.
REQ-008 Port sig_in, input, 1 bit; asynchronous clock-like signal under measurement (e.g. a divided PLL output).
REQ-009 Port busy, output, 1 bit; high while a measurement is in progress.
REQ-010 Port done, output, 1 bit; one-cycle pulse when count, in_range and overflow are updated.
REQ-011 Port count, output, CNT_W bits; rising edges of sig_in seen in the last gate window.
REQ-012 Port in_range, output, 1 bit; count lies within EXP_MIN..EXP_MAX inclusive and overflow is low.
REQ-013 Port overflow, output, 1 bit; the edge counter saturated during the last window.

Function
REQ-014 sig_in SHALL pass through a 2-flop synchronizer, then a third flop for edge detection.
- Edge = stage2 high and stage3 low.
- Latency from a sig_in rise to edge detection: 2-3 clk cycles.
REQ-015 States: IDLE, GATE, DONE.
REQ-016 IDLE -> GATE when start=1. On entry the gate timer and edge counter SHALL clear.
REQ-017 GATE SHALL last exactly GATE_CYCLES clk cycles and count every detected edge, including one detected on the final gate cycle.
REQ-018 GATE -> DONE after the last gate cycle.
- DONE lasts 1 cycle: done=1; count, overflow and in_range are registered.
- DONE -> IDLE.
REQ-019 busy SHALL be 1 in GATE and DONE, 0 in IDLE.
REQ-020 start SHALL be ignored while busy=1; no restart and no window extension.
REQ-021 The edge counter SHALL saturate at 2^CNT_W-1 and set an internal overflow flag; further edges SHALL be ignored.
REQ-022 count, in_range and overflow SHALL hold their values between DONE pulses.
REQ-023 The edge detector SHALL keep running in IDLE, but edges seen outside GATE SHALL NOT be counted.
REQ-024 sig_in held constant for the whole window SHALL give count=0 and in_range=0 (for EXP_MIN>0).

Reset
REQ-025 On rst=1, asynchronously:
- state=IDLE;
- busy=0, done=0, count=0, in_range=0, overflow=0;
- synchronizer flops, gate timer and edge counter cleared.
REQ-026 A reset during GATE SHALL abort the measurement with no done pulse and outputs at their reset values.
REQ-027 After rst falls, the first start is accepted on the first clk edge with rst=0.

Configuration
REQ-028 Macro FREQ_METER_CONT_EN SHALL select the operating mode.
- Defined: DONE goes straight to GATE, restarting the timer and counter, so measurement is continuous.
  - start is needed only once after reset.
  - busy stays 1 after the first start.
  - done pulses every GATE_CYCLES+1 cycles.
- Undefined: single-shot behaviour per REQ-016..REQ-018.

Verification
REQ-029 sig_in period 80 ns, GATE_CYCLES=1000, one start pulse -> after 1001 cycles done=1, count in 249..251, in_range=1, overflow=0.
REQ-030 sig_in held 0, start pulse -> done after 1001 cycles, count=0, in_range=0, overflow=0.
REQ-031 CNT_W=4, sig_in period 80 ns, start pulse -> count=15, overflow=1, in_range=0.
REQ-032 start pulsed again 10 cycles into GATE -> exactly one done pulse, 1001 cycles after the first start.
REQ-033 rst asserted 500 cycles into GATE -> all outputs 0 immediately, no done pulse; a new start then measures normally, count 249..251.
REQ-034 With FREQ_METER_CONT_EN defined, sig_in period 80 ns, one start pulse -> done pulses at 1001-cycle intervals, each with count in 249..251 and busy constantly 1.
